// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALUOp/funct encodings and the issue-stage entry record.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_RTYPE = 2'b10,
        OP_ORI   = 2'b11
    } alu_op_e;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Entry record at the default datapath widths, for consumers of the stage outputs.
    typedef struct packed {
        logic [3:0]            ctl;
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
        logic [REG_W_DEF-1:0]  dst;
        logic                  illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUOp/funct -> 4-bit ALUctl decode; unknown R-type funct flags illegal.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_ctl,
    output logic       o_illegal
);

    always_comb begin
        o_ctl     = ALU_AND;
        o_illegal = 1'b0;
        case (alu_op_e'(i_alu_op))
            OP_ADD: o_ctl = ALU_ADD;
            OP_SUB: o_ctl = ALU_SUB;
            OP_ORI: o_ctl = ALU_OR;
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_ctl = ALU_ADD;
                    FN_SUB:  o_ctl = ALU_SUB;
                    FN_AND:  o_ctl = ALU_AND;
                    FN_OR:   o_ctl = ALU_OR;
                    FN_SLT:  o_ctl = ALU_SLT;
                    FN_NOR:  o_ctl = ALU_NOR;
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_ctl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage feeding MIPSALU: decode, operand-B select, main+skid registers.
// One-cycle latency when empty; in_ready comes straight from the skid flag.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_alu_op,
    input  logic [5:0]       in_funct,
    input  logic             in_alu_src,
    input  logic [WIDTH-1:0] in_rs_data,
    input  logic [WIDTH-1:0] in_rt_data,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [REG_W-1:0] in_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALUctl,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [REG_W-1:0] out_dst,
    output logic             out_illegal
);

    typedef struct packed {
        logic [3:0]       ctl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [REG_W-1:0] dst;
        logic             illegal;
    } stage_entry_t;

    logic [3:0]       w_ctl;
    logic             w_illegal;
    logic [WIDTH-1:0] w_imm_ext;
    logic             w_acc;
    logic             w_cons;
    stage_entry_t     w_new;

    stage_entry_t     r_main;
    stage_entry_t     r_skid;
    logic             r_main_vld;
    logic             r_skid_vld;

    alu_ctl_decode u_decode (
        .i_alu_op  (in_alu_op),
        .i_funct   (in_funct),
        .o_ctl     (w_ctl),
        .o_illegal (w_illegal)
    );

    // ORI treats the immediate as unsigned; every other op sign-extends it.
    assign w_imm_ext = (alu_op_e'(in_alu_op) == OP_ORI)
                     ? {{(WIDTH-IMM_W){1'b0}}, in_imm}
                     : {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm};

    assign w_new.ctl     = w_ctl;
    assign w_new.a       = in_rs_data;
    assign w_new.b       = in_alu_src ? w_imm_ext : in_rt_data;
    assign w_new.dst     = in_dst;
    assign w_new.illegal = w_illegal;

    assign in_ready = !r_skid_vld;
    assign w_acc    = in_valid && in_ready;
    assign w_cons   = r_main_vld && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_main_vld || w_cons) begin
            // Skid is only ever full alongside a full main, so it drains first to keep order.
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_main_vld <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_acc) begin
                r_main     <= w_new;
                r_main_vld <= 1'b1;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid     <= w_new;
            r_skid_vld <= 1'b1;
        end
    end

    assign out_valid   = r_main_vld;
    assign ALUctl      = r_main.ctl;
    assign A           = r_main.a;
    assign B           = r_main.b;
    assign out_dst     = r_main.dst;
    assign out_illegal = r_main.illegal;

endmodule
